crossbar_gather: RTL and testbench

Output-driven N-to-N gather network: each output port names the input it wants, and the block pulls that input's word into a per-output register. Inputs and outputs use valid/ready handshakes, so slow outputs stall the sources. When several outputs select the same input, that input is consumed once and delivered to all of them in the same cycle (all-or-nothing multicast). The block sits on the collection side of the distribute crossbar, which is index-driven by its inputs and has no flow control.

---
 rtl/crossbar_pkg.sv | 21 ++
 rtl/crossbar_gather_if.sv | 39 +++
 rtl/crossbar_gather_port.sv | 52 +++++
 rtl/crossbar_gather.sv | 106 ++++++++++
 tb/tb_crossbar_gather.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: default geometry and the source-index width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package crossbar_pkg;

    localparam int N_DEFAULT       = 8;
    localparam int DW_DATA_DEFAULT = 32;

    // Width of a port index. The result is at least 1, so a single-port
    // crossbar still gets a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy of one gather output register.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/crossbar_gather_if.sv
// Handshake bundle of the gather crossbar: N source ports, N request ports, N output ports.
// Latency: n/a (wires only).
// Backpressure: in_ready/req_ready flow to sources and requesters; out_ready flows in from sinks.
// Ports (per bundle):
//   in_valid/in_data/in_ready     source side, word i in in_data[i*DW_DATA +: DW_DATA]
//   req_valid/req_src/req_ready   output j names its source in req_src[j*DW_IDX +: DW_IDX]
//   out_valid/out_data/out_ready  registered output words towards the sinks
interface crossbar_gather_if
    import crossbar_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int DW_DATA = DW_DATA_DEFAULT
);
    localparam int DW_IDX = idx_width(N);

    logic [N-1:0]         in_valid;
    logic [N*DW_DATA-1:0] in_data;
    logic [N-1:0]         in_ready;

    logic [N-1:0]         req_valid;
    logic [N*DW_IDX-1:0]  req_src;
    logic [N-1:0]         req_ready;

    logic [N-1:0]         out_valid;
    logic [N*DW_DATA-1:0] out_data;
    logic [N-1:0]         out_ready;

    // Environment side: drives sources, requests and sink readiness.
    modport master (
        output in_valid, in_data, req_valid, req_src, out_ready,
        input  in_ready, req_ready, out_valid, out_data
    );

    // Crossbar side.
    modport slave (
        input  in_valid, in_data, req_valid, req_src, out_ready,
        output in_ready, req_ready, out_valid, out_data
    );
endinterface

// File: rtl/crossbar_gather_port.sv
// One gather output register slice: holds a single word until the sink takes it.
// Latency: a load in cycle t is visible on out_valid/out_data in cycle t+1.
// Backpressure: free is high when empty or draining, so a full slot can reload back-to-back.
// Ports:
//   clk, rst (async, active-low)
//   load, load_data   write strobe and word from the selected source
//   out_ready         sink accepts the held word this cycle
//   out_valid, out_data, free
module crossbar_gather_port
    import crossbar_pkg::*;
#(
    parameter int DW_DATA = DW_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DW_DATA-1:0] load_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DW_DATA-1:0] out_data,
    output logic               free
);
    slot_state_e        state_q, state_d;
    logic [DW_DATA-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            // A load in the same cycle as the drain keeps the slot full.
            SLOT_FULL:  if (!load && out_ready) state_d = SLOT_EMPTY;
        endcase
        // Data only changes on load; a drained slot keeps its last word.
        if (load) data_d = load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign free      = (state_q == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/crossbar_gather.sv
// Output-driven N-to-N gather: each output names a source and pulls its word, multicast all-or-nothing.
// Latency: one cycle from source fire to out_valid/out_data; in_ready/req_ready are combinational.
// Backpressure: a source is consumed only when every output requesting it is free; otherwise all wait.
// Ports:
//   clk, rst (async, active-low)
//   bus   gather handshake bundle (slave side)
//   err   sticky: some request named a source index >= N
module crossbar_gather
    import crossbar_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int DW_DATA = DW_DATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    crossbar_gather_if.slave       bus,
    output logic                   err
);
    localparam int DW_IDX = idx_width(N);

    logic [DW_IDX-1:0]  src_idx   [N];
    logic [DW_DATA-1:0] in_word   [N];
    logic [DW_DATA-1:0] load_data [N];
    logic [N-1:0]       src_ok;
    logic [N-1:0]       bad_req;
    logic [N-1:0]       any_hit;
    logic [N-1:0]       all_free;
    logic [N-1:0]       fire;
    logic [N-1:0]       load;
    logic [N-1:0]       free;
    logic               err_q, err_d;

    // Unpack the flat buses and classify each request.
    always_comb begin
        src_ok  = '0;
        bad_req = '0;
        for (int j = 0; j < N; j++) begin
            src_idx[j] = bus.req_src[j*DW_IDX +: DW_IDX];
            in_word[j] = bus.in_data[j*DW_DATA +: DW_DATA];
            src_ok[j]  = bus.req_valid[j] && (int'(src_idx[j]) < N);
            bad_req[j] = bus.req_valid[j] && !(int'(src_idx[j]) < N);
        end
    end

    // Hit matrix reduced per source: a source is ready only if it has at
    // least one requester and every one of them can take the word now.
    // This deliberately ignores in_valid so in_ready never depends on it.
    always_comb begin
        any_hit  = '0;
        all_free = '1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (src_ok[j] && (int'(src_idx[j]) == i)) begin
                    any_hit[i] = 1'b1;
                    if (!free[j]) all_free[i] = 1'b0;
                end
            end
        end
    end

    assign bus.in_ready = any_hit & all_free;
    assign fire         = bus.in_valid & any_hit & all_free;

    // Per-output source mux. Each output selects exactly one source, so
    // there is never more than one writer per output register.
    always_comb begin
        load = '0;
        for (int j = 0; j < N; j++) begin
            load[j]      = src_ok[j] && fire[src_idx[j]];
            load_data[j] = src_ok[j] ? in_word[src_idx[j]] : '0;
        end
    end

    assign bus.req_ready = load;

    for (genvar j = 0; j < N; j++) begin : g_port
        crossbar_gather_port #(
            .DW_DATA (DW_DATA)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .load      (load[j]),
            .load_data (load_data[j]),
            .out_ready (bus.out_ready[j]),
            .out_valid (bus.out_valid[j]),
            .out_data  (bus.out_data[j*DW_DATA +: DW_DATA]),
            .free      (free[j])
        );
    end

    // Out-of-range requests are never served; flag them until reset.
    always_comb begin
        err_d = err_q | (|bad_req);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_crossbar_gather.sv
// Directed bench for crossbar_gather: an N=8 instance for the datapath and an N=6 instance for bad indices.
// Latency: checks registered outputs one cycle after fire, combinational readies mid-cycle.
// Backpressure: exercises stalled multicast, back-to-back streaming and a held output.
module tb_crossbar_gather;
    import crossbar_pkg::*;

    logic clk;
    logic rst;
    logic err8, err6;

    crossbar_gather_if #(.N(8), .DW_DATA(32)) bus8 ();
    crossbar_gather_if #(.N(6), .DW_DATA(32)) bus6 ();

    crossbar_gather #(.N(8), .DW_DATA(32)) dut8 (
        .clk (clk), .rst (rst), .bus (bus8), .err (err8)
    );
    crossbar_gather #(.N(6), .DW_DATA(32)) dut6 (
        .clk (clk), .rst (rst), .bus (bus6), .err (err6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    task automatic set_src8(input int j, input int v);
        bus8.req_src[j*3 +: 3] = 3'(v);
    endtask
    task automatic set_data8(input int i, input logic [31:0] v);
        bus8.in_data[i*32 +: 32] = v;
    endtask
    task automatic set_src6(input int j, input int v);
        bus6.req_src[j*3 +: 3] = 3'(v);
    endtask
    task automatic set_data6(input int i, input logic [31:0] v);
        bus6.in_data[i*32 +: 32] = v;
    endtask
    function automatic logic [31:0] out8(input int j);
        return bus8.out_data[j*32 +: 32];
    endfunction
    function automatic logic [31:0] out6(input int j);
        return bus6.out_data[j*32 +: 32];
    endfunction

    task automatic load_unicast8(input logic [7:0] ordy);
        for (int j = 0; j < 8; j++) set_src8(j, 7 - j);
        for (int i = 0; i < 8; i++) set_data8(i, 32'hA0 + 32'(i));
        bus8.in_valid  = 8'hFF;
        bus8.req_valid = 8'hFF;
        bus8.out_ready = ordy;
    endtask

    initial begin
        rst = 1'b0;
        bus8.in_valid = '0; bus8.in_data = '0; bus8.req_valid = '0; bus8.req_src = '0; bus8.out_ready = '0;
        bus6.in_valid = '0; bus6.in_data = '0; bus6.req_valid = '0; bus6.req_src = '0; bus6.out_ready = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", bus8.out_valid, 8'h00);
        check("rst_err8", err8, 1'b0);
        check("rst_err6", err6, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("rst_out_data%0d", j), out8(j), 32'h0);
        check("rst_in_ready_noreq", bus8.in_ready, 8'h00);
        bus8.req_valid = 8'h01;
        set_src8(0, 3);
        #1;
        check("rst_in_ready_req", bus8.in_ready, 8'h08);
        check("rst_req_ready_noinput", bus8.req_ready, 8'h00);
        bus8.req_valid = '0;
        #1;
        rst = 1'b1;

        // ---------------- unicast ----------------
        step();
        load_unicast8(8'hFF);
        settle();
        check("uni_in_ready", bus8.in_ready, 8'hFF);
        check("uni_req_ready", bus8.req_ready, 8'hFF);
        step();
        check("uni_out_valid", bus8.out_valid, 8'hFF);
        check("uni_out0", out8(0), 32'hA7);
        check("uni_out3", out8(3), 32'hA4);
        check("uni_out7", out8(7), 32'hA0);
        bus8.in_valid = '0;
        bus8.req_valid = '0;
        step();
        check("uni_drain", bus8.out_valid, 8'h00);
        check("uni_hold_data", out8(0), 32'hA7);

        // ---------------- multicast with stall ----------------
        bus8.out_ready = 8'h00;
        bus8.req_valid = 8'h08;
        set_src8(3, 1);
        set_data8(1, 32'h11);
        bus8.in_valid = 8'h02;
        settle();
        check("mc_prefill_req_ready", bus8.req_ready, 8'h08);
        step();
        check("mc_prefill_valid", bus8.out_valid, 8'h08);
        check("mc_prefill_data", out8(3), 32'h11);
        bus8.req_valid = 8'h29;
        set_src8(0, 2); set_src8(3, 2); set_src8(5, 2);
        set_data8(2, 32'h55);
        bus8.in_valid = 8'h04;
        bus8.out_ready = 8'hF7;
        settle();
        check("mc_stall_in_ready", bus8.in_ready, 8'h00);
        check("mc_stall_req_ready", bus8.req_ready, 8'h00);
        step();
        check("mc_stall_valid", bus8.out_valid, 8'h08);
        check("mc_stall_out3", out8(3), 32'h11);
        check("mc_stall_out0", out8(0), 32'hA7);
        bus8.out_ready = 8'hFF;
        settle();
        check("mc_go_in_ready", bus8.in_ready, 8'h04);
        check("mc_go_req_ready", bus8.req_ready, 8'h29);
        step();
        bus8.req_valid = '0;
        bus8.in_valid = '0;
        bus8.out_ready = 8'h00;
        check("mc_valid", bus8.out_valid, 8'h29);
        check("mc_out0", out8(0), 32'h55);
        check("mc_out3", out8(3), 32'h55);
        check("mc_out5", out8(5), 32'h55);
        step();
        check("mc_held", bus8.out_valid, 8'h29);
        bus8.out_ready = 8'hFF;
        step();
        check("mc_once", bus8.out_valid, 8'h00);

        // ---------------- back-to-back stream ----------------
        bus8.req_valid = 8'h02;
        set_src8(1, 4);
        bus8.in_valid = 8'h10;
        bus8.out_ready = 8'hFF;
        for (int k = 1; k <= 5; k++) begin
            set_data8(4, 32'(k));
            settle();
            check($sformatf("b2b_req_ready%0d", k), bus8.req_ready, 8'h02);
            step();
            check($sformatf("b2b_valid%0d", k), bus8.out_valid, 8'h02);
            check($sformatf("b2b_data%0d", k), out8(1), 32'(k));
        end
        set_data8(4, 32'd6);
        bus8.out_ready = 8'h00;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("b2b_stall_in_ready%0d", c), bus8.in_ready, 8'h00);
            check($sformatf("b2b_stall_req_ready%0d", c), bus8.req_ready, 8'h00);
            step();
            check($sformatf("b2b_stall_data%0d", c), out8(1), 32'd5);
            check($sformatf("b2b_stall_valid%0d", c), bus8.out_valid, 8'h02);
        end
        bus8.out_ready = 8'hFF;
        settle();
        check("b2b_resume_in_ready", bus8.in_ready, 8'h10);
        step();
        check("b2b_resume_data", out8(1), 32'd6);
        bus8.req_valid = '0;
        bus8.in_valid = '0;
        step();
        check("b2b_drain", bus8.out_valid, 8'h00);

        // ---------------- idle input ----------------
        bus8.in_valid = 8'h40;
        set_data8(6, 32'h66);
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("idle_in_ready%0d", c), bus8.in_ready, 8'h00);
            step();
            check($sformatf("idle_valid%0d", c), bus8.out_valid, 8'h00);
            check($sformatf("idle_data%0d", c), out8(1), 32'd6);
        end
        bus8.in_valid = '0;

        // ---------------- bad index (N=6) ----------------
        bus6.req_valid = 6'b000101;
        set_src6(0, 1);
        set_src6(2, 7);
        for (int i = 0; i < 6; i++) set_data6(i, 32'h10 + 32'(i));
        bus6.in_valid = 6'h3F;
        bus6.out_ready = 6'h3F;
        settle();
        check("bad_err_before", err6, 1'b0);
        check("bad_req_ready", bus6.req_ready, 6'h01);
        check("bad_in_ready", bus6.in_ready, 6'h02);
        step();
        check("bad_err_set", err6, 1'b1);
        check("bad_other_valid", bus6.out_valid, 6'h01);
        check("bad_other_data", out6(0), 32'h11);
        bus6.req_valid = 6'b000100;
        settle();
        check("bad_req_ready_held", bus6.req_ready, 6'h00);
        step();
        check("bad_err_held", err6, 1'b1);
        bus6.req_valid = '0;
        step();
        check("bad_err_sticky", err6, 1'b1);
        check("bad_err8_clean", err8, 1'b0);

        // ---------------- reset mid-stream ----------------
        load_unicast8(8'h00);
        step();
        bus8.req_valid = '0;
        bus8.in_valid = '0;
        check("rstm_full", bus8.out_valid, 8'hFF);
        #3;
        rst = 1'b0;
        #1;
        check("rstm_valid", bus8.out_valid, 8'h00);
        check("rstm_data0", out8(0), 32'h0);
        check("rstm_data7", out8(7), 32'h0);
        check("rstm_err6", err6, 1'b0);
        step();
        check("rstm_valid_hold", bus8.out_valid, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
